// File: rtl/shift_reg_sync_set_reset.sv
// WIDTH-bit universal register: hold, load, shift left/right, optional rotate.
// Synchronous active-high reset and set; reset has priority over set.
module shift_reg_sync_set_reset #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic [1:0]       mode,
   input  logic             rotate,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_lsb,
   input  logic             sin_msb,
   output logic [WIDTH-1:0] q,
   output logic             msb_out,
   output logic             lsb_out
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_SHL   = 2'b10;
   localparam logic [1:0] MODE_SHR   = 2'b11;

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("shift_reg_sync_set_reset: WIDTH must be >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] nxt;
   logic             left_in;
   logic             right_in;

   // Per-bit 4:1 mode mux; rotate swaps the serial inputs for the far-end bit
   always_comb begin
      left_in  = rotate ? q[WIDTH-1] : sin_lsb;
      right_in = rotate ? q[0]       : sin_msb;
      nxt      = q;
      unique case (mode)
         MODE_HOLD: nxt = q;
         MODE_LOAD: nxt = d;
         MODE_SHL:  nxt = {q[WIDTH-2:0], left_in};
         MODE_SHR:  nxt = {right_in, q[WIDTH-1:1]};
      endcase
   end

   // State register: reset beats set, set beats the mode mux
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (set) begin
         q <= '1;
      end else begin
         q <= nxt;
      end
   end

   assign msb_out = q[WIDTH-1];
   assign lsb_out = q[0];

endmodule

// File: tb/tb_shift_reg_sync_set_reset.sv
// Bench for shift_reg_sync_set_reset (WIDTH=8): directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_shift_reg_sync_set_reset;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       set = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       rotate = 1'b0;
   logic [7:0] d = 8'h00;
   logic       sin_lsb = 1'b0;
   logic       sin_msb = 1'b0;
   logic [7:0] q;
   logic       msb_out;
   logic       lsb_out;

   logic [7:0] exp_q;
   int         vec = 0;
   int         err = 0;

   shift_reg_sync_set_reset #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .set     (set),
      .mode    (mode),
      .rotate  (rotate),
      .d       (d),
      .sin_lsb (sin_lsb),
      .sin_msb (sin_msb),
      .q       (q),
      .msb_out (msb_out),
      .lsb_out (lsb_out)
   );

   always #5 clk = ~clk;

   // Reference: value-level arithmetic, shifting by multiply/divide
   function automatic logic [7:0] ref_next(
      input logic [7:0] cur, input bit r, input bit s, input logic [1:0] m,
      input bit rot, input logic [7:0] dd, input bit sl, input bit sm);
      int v;
      int top;
      int bot;
      if (r) return 8'h00;
      if (s) return 8'hFF;
      v = int'(cur);
      top = v / 128;
      bot = v % 2;
      case (m)
         2'd0: return cur;
         2'd1: return dd;
         2'd2: return 8'(((v * 2) % 256) + (rot ? top : int'(sl)));
         default: return 8'((v / 2) + 128 * (rot ? bot : int'(sm)));
      endcase
   endfunction

   task automatic drive(input bit r, input bit s, input logic [1:0] m,
                        input bit rot, input logic [7:0] dd,
                        input bit sl, input bit sm);
      @(negedge clk);
      reset = r; set = s; mode = m; rotate = rot;
      d = dd; sin_lsb = sl; sin_msb = sm;
      exp_q = ref_next(exp_q, r, s, m, rot, dd, sl, sm);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(1, 0, 2'b01, 0, 8'hA5, 1, 1);
      vec++;
      if (q !== 8'h00 || msb_out !== 1'b0 || lsb_out !== 1'b0) begin
         err++;
         $display("FAIL reset q=%h msb=%b lsb=%b want 00/0/0", q, msb_out, lsb_out);
      end
      drive(0, 0, 2'b01, 0, 8'hA5, 0, 0);
      vec++;
      if (q !== 8'hA5 || msb_out !== 1'b1 || lsb_out !== 1'b1) begin
         err++;
         $display("FAIL load_a5 q=%h msb=%b lsb=%b want a5/1/1", q, msb_out, lsb_out);
      end
   endtask

   task automatic test_shift_left;
      drive(0, 0, 2'b10, 0, 8'h00, 0, 1);
      vec++;
      if (q !== 8'h4A) begin
         err++;
         $display("FAIL shl1 q=%h want 4a", q);
      end
      drive(0, 0, 2'b10, 0, 8'hFF, 0, 1);
      vec++;
      if (q !== 8'h94) begin
         err++;
         $display("FAIL shl2 q=%h want 94", q);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 2'b00, 1'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom));
         // Wiggle inputs mid-cycle; q must not move before the edge
         d = 8'($urandom); mode = 2'b01; sin_lsb = ~sin_lsb;
         #2;
         vec++;
         if (q !== 8'h94 || msb_out !== 1'b1 || lsb_out !== 1'b0) begin
            err++;
            $display("FAIL hold%0d q=%h want 94", i, q);
         end
      end
   endtask

   task automatic test_rotate;
      drive(0, 0, 2'b01, 0, 8'h81, 0, 0);
      drive(0, 0, 2'b11, 1, 8'h00, 1, 0);
      vec++;
      if (q !== 8'hC0) begin
         err++;
         $display("FAIL rotr q=%h want c0", q);
      end
      drive(0, 0, 2'b10, 1, 8'h00, 0, 1);
      vec++;
      if (q !== 8'h81) begin
         err++;
         $display("FAIL rotl q=%h want 81", q);
      end
   endtask

   task automatic test_fill_right;
      drive(1, 0, 2'b00, 0, 8'h00, 0, 0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 2'b11, 0, 8'($urandom), 1'($urandom), 1);
         vec++;
         if (int'(q) !== 256 - (1 << (7 - i))) begin
            err++;
            $display("FAIL fill%0d q=%h want %h", i, q, 256 - (1 << (7 - i)));
         end
      end
      drive(0, 1, 2'b01, 0, 8'h00, 0, 0);
      vec++;
      if (q !== 8'hFF) begin
         err++;
         $display("FAIL set_over_load q=%h want ff", q);
      end
   endtask

   task automatic test_set_reset_priority;
      drive(0, 0, 2'b01, 0, 8'h3C, 0, 0);
      drive(1, 1, 2'b01, 0, 8'h3C, 1, 1);
      vec++;
      if (q !== 8'h00) begin
         err++;
         $display("FAIL reset_over_set q=%h want 00", q);
      end
      drive(0, 1, 2'b00, 0, 8'h00, 0, 0);
      vec++;
      if (q !== 8'hFF || msb_out !== 1'b1 || lsb_out !== 1'b1) begin
         err++;
         $display("FAIL set_alone q=%h want ff", q);
      end
   endtask

   task automatic test_reset_mid;
      drive(0, 0, 2'b01, 0, 8'hF0, 0, 0);
      drive(0, 0, 2'b10, 0, 8'h00, 0, 0);
      drive(0, 0, 2'b10, 0, 8'h00, 0, 0);
      vec++;
      if (q !== 8'hC0) begin
         err++;
         $display("FAIL mid_shift q=%h want c0", q);
      end
      drive(1, 0, 2'b10, 0, 8'h00, 1, 0);
      vec++;
      if (q !== 8'h00) begin
         err++;
         $display("FAIL mid_reset q=%h want 00", q);
      end
      drive(0, 0, 2'b10, 0, 8'h00, 1, 0);
      vec++;
      if (q !== 8'h01) begin
         err++;
         $display("FAIL resume q=%h want 01", q);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
               2'($urandom), 1'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom));
         vec++;
         if (q !== exp_q || msb_out !== exp_q[7] || lsb_out !== exp_q[0]) begin
            err++;
            $display("FAIL rand%0d q=%h msb=%b lsb=%b want %h", i, q,
                     msb_out, lsb_out, exp_q);
         end
      end
   endtask

   initial begin
      exp_q = 8'h00;
      test_reset;
      test_shift_left;
      test_rotate;
      test_fill_right;
      test_set_reset_priority;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
